// File: rtl/oam_dma.sv
// OAM DMA bus initiator: copies XFER_LEN bytes from page {src_page,8'h00}
// to DST_BASE, one byte per CYC_PER_BYTE-clock slot, after START_DELAY idle
// slots. busy stalls the CPU bus; done pulses once after the last write.
module oam_dma #(
  parameter int          CYC_PER_BYTE = 4,
  parameter int          XFER_LEN     = 160,
  parameter int          START_DELAY  = 1,
  parameter logic [15:0] DST_BASE     = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  src_page,
  output logic [15:0] r_addr,
  input  logic [7:0]  r_data,
  output logic        wen,
  output logic [15:0] w_addr,
  output logic [7:0]  w_data,
  output logic        busy,
  output logic        done
);

  localparam int CW = (CYC_PER_BYTE > 1) ? $clog2(CYC_PER_BYTE) : 1;
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYC_PER_BYTE - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [7:0]    IDX_LAST = 8'(XFER_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cyc;
  logic [DW-1:0] dly;
  logic [7:0]    idx;
  logic [7:0]    page;
  logic          wr_slot;

  // Echo RAM pages E0-FF alias C0-DF, so fold them down when latching.
  function automatic logic [7:0] map_page(input logic [7:0] p);
    return (p > 8'hDF) ? (p - 8'h20) : p;
  endfunction

  assign wr_slot = (state == XFER) && (cyc == CYC_LAST);

  // Memory port is only driven during the last clock of a transfer slot.
  always_comb begin
    wen    = 1'b0;
    r_addr = 16'h0000;
    w_addr = 16'h0000;
    w_data = 8'h00;
    if (wr_slot) begin
      wen    = 1'b1;
      r_addr = {page, idx};
      w_addr = DST_BASE + {8'h00, idx};
      w_data = r_data;
    end
  end

  // Sequencer: a start strobe always (re)arms a fresh transfer, aborting
  // any transfer in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cyc   <= '0;
      dly   <= '0;
      idx   <= 8'h00;
      page  <= 8'h00;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        page  <= map_page(src_page);
        cyc   <= '0;
        dly   <= '0;
        idx   <= 8'h00;
        busy  <= 1'b1;
        state <= (START_DELAY == 0) ? XFER : DELAY;
      end else begin
        unique case (state)
          IDLE: begin
          end
          DELAY: begin
            if (cyc == CYC_LAST) begin
              cyc <= '0;
              if (dly == DLY_LAST) begin
                dly   <= '0;
                state <= XFER;
              end else begin
                dly <= dly + DW'(1);
              end
            end else begin
              cyc <= cyc + CW'(1);
            end
          end
          XFER: begin
            if (cyc == CYC_LAST) begin
              cyc <= '0;
              if (idx == IDX_LAST) begin
                idx   <= 8'h00;
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                idx <= idx + 8'd1;
              end
            end else begin
              cyc <= cyc + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a table-driven run of a short-transfer instance plus
// scoreboarded multi-cycle sequences on a default-parameter instance.
module tb_oam_dma;

  logic        clk;
  logic        rst_n;
  logic        start, start5;
  logic [7:0]  src_page, page5;
  logic [15:0] r_addr, r_addr5, w_addr, w_addr5;
  logic [7:0]  r_data, r_data5, w_data, w_data5;
  logic        wen, wen5, busy, busy5, done, done5;

  int nvec = 0;
  int nerr = 0;
  int tcyc = 0;

  typedef struct {
    int          cyc;
    logic [15:0] ra;
    logic [15:0] wa;
    logic [7:0]  wd;
  } wr_t;

  typedef struct {
    logic        st;
    logic [7:0]  pg;
    logic        busy;
    logic        done;
    logic        wen;
    logic [15:0] ra;
    logic [15:0] wa;
    logic [7:0]  wd;
  } vec_t;

  wr_t  exp_q[$];
  int   done_q[$];
  int   b_from = 0;
  int   b_until = 0;

  logic [7:0]  dst [256];
  logic        cap_wen;
  logic [15:0] cap_addr;
  logic [7:0]  cap_data;

  // Source memory contents: distinct per page, C0 page holds i^5A.
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
  endfunction

  assign r_data  = pat(r_addr);
  assign r_data5 = pat(r_addr5);

  oam_dma u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_page(src_page),
    .r_addr(r_addr), .r_data(r_data), .wen(wen), .w_addr(w_addr),
    .w_data(w_data), .busy(busy), .done(done)
  );

  oam_dma #(.CYC_PER_BYTE(1), .XFER_LEN(4), .START_DELAY(0)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .src_page(page5),
    .r_addr(r_addr5), .r_data(r_data5), .wen(wen5), .w_addr(w_addr5),
    .w_data(w_data5), .busy(busy5), .done(done5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) tcyc <= tcyc + 1;

  // Destination page memory commits on the edge that ends the write cycle.
  always @(posedge clk) begin
    if (cap_wen && cap_addr[15:8] == 8'hFE) dst[cap_addr[7:0]] <= cap_data;
  end

  // Scoreboard monitor for the default instance, sampled mid-cycle.
  always @(negedge clk) begin
    cap_wen  <= wen;
    cap_addr <= w_addr;
    cap_data <= w_data;
    while (exp_q.size() > 0 && exp_q[0].cyc < tcyc) begin
      nvec++; nerr++;
      $display("FAIL missed_write: expected cycle %0d waddr %h, got wen=0 (now %0d)",
               exp_q[0].cyc, exp_q[0].wa, tcyc);
      void'(exp_q.pop_front());
    end
    if (wen) begin
      nvec++;
      if (exp_q.size() > 0 && exp_q[0].cyc == tcyc) begin
        if (r_addr !== exp_q[0].ra || w_addr !== exp_q[0].wa || w_data !== exp_q[0].wd) begin
          nerr++;
          $display("FAIL write_cycle_%0d: got ra=%h wa=%h wd=%h, want ra=%h wa=%h wd=%h",
                   tcyc, r_addr, w_addr, w_data, exp_q[0].ra, exp_q[0].wa, exp_q[0].wd);
        end
        void'(exp_q.pop_front());
      end else begin
        nerr++;
        $display("FAIL unexpected_write: cycle %0d wa=%h wd=%h, want wen=0", tcyc, w_addr, w_data);
      end
    end
    while (done_q.size() > 0 && done_q[0] < tcyc) begin
      nvec++; nerr++;
      $display("FAIL missed_done: expected in cycle %0d, got none", done_q[0]);
      void'(done_q.pop_front());
    end
    if (done || (done_q.size() > 0 && done_q[0] == tcyc)) begin
      nvec++;
      if (done && done_q.size() > 0 && done_q[0] == tcyc) begin
        void'(done_q.pop_front());
      end else begin
        nerr++;
        $display("FAIL done_cycle_%0d: got done=%b, want %b", tcyc, done, ~done);
        if (done_q.size() > 0 && done_q[0] == tcyc) void'(done_q.pop_front());
      end
    end
    nvec++;
    if (busy !== ((tcyc > b_from) && (tcyc < b_until))) begin
      nerr++;
      $display("FAIL busy_cycle_%0d: got %b, want %b", tcyc, busy, (tcyc > b_from) && (tcyc < b_until));
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive start in the current cycle and queue what that trigger implies.
  task automatic trig(input logic [7:0] pg);
    logic [7:0] mp;
    wr_t e;
    mp = (pg > 8'hDF) ? (pg - 8'h20) : pg;
    while (exp_q.size() > 0 && exp_q[$].cyc > tcyc) void'(exp_q.pop_back());
    while (done_q.size() > 0 && done_q[$] > tcyc) void'(done_q.pop_back());
    for (int i = 0; i < 160; i++) begin
      e.cyc = tcyc + 1 + (1 + i) * 4 + 3;
      e.ra  = {mp, 8'(i)};
      e.wa  = 16'hFE00 + 16'(i);
      e.wd  = pat(e.ra);
      exp_q.push_back(e);
    end
    done_q.push_back(tcyc + 1 + (1 + 160) * 4);
    if (!((tcyc > b_from) && (tcyc < b_until))) b_from = tcyc;
    b_until = tcyc + 1 + (1 + 160) * 4;
    start    = 1'b1;
    src_page = pg;
    next_cyc();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      next_cyc();
      n++;
    end
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL timeout: %0d writes and %0d done pulses outstanding", exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
    repeat (2) next_cyc();
  endtask

  task automatic fill_dst();
    for (int i = 0; i < 256; i++) dst[i] <= 8'hEE;
    next_cyc();
  endtask

  task automatic check_dst(input string name, input logic [7:0] pg, input int nwr);
    logic [7:0] ex;
    for (int i = 0; i < 256; i++) begin
      ex = (i < nwr) ? pat({pg, 8'(i)}) : 8'hEE;
      nvec++;
      if (dst[i] !== ex) begin
        nerr++;
        $display("FAIL %s_dst_FE%02h: got %h, want %h", name, i[7:0], dst[i], ex);
      end
    end
  endtask

  vec_t tbl[20];

  initial begin
    rst_n = 1'b0; start = 1'b0; src_page = 8'h00; start5 = 1'b0; page5 = 8'h00;
    cap_wen = 1'b0; cap_addr = 16'h0; cap_data = 8'h0;

    //        st    pg     busy done wen  ra        wa        wd
    tbl[0]  = '{1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hC000, 16'hFE00, 8'h5A};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hC001, 16'hFE01, 8'h5B};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hC002, 16'hFE02, 8'h58};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hC003, 16'hFE03, 8'h59};
    tbl[5]  = '{1'b1, 8'hE2, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 8'h00};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hC200, 16'hFE00, 8'h58};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hC201, 16'hFE01, 8'h59};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hC202, 16'hFE02, 8'h5A};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hC203, 16'hFE03, 8'h5B};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 8'h00};
    tbl[11] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h1000, 16'hFE00, 8'h0A};
    tbl[13] = '{1'b1, 8'hDF, 1'b1, 1'b0, 1'b1, 16'h1001, 16'hFE01, 8'h0B};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hDF00, 16'hFE00, 8'h45};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hDF01, 16'hFE01, 8'h44};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hDF02, 16'hFE02, 8'h47};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hDF03, 16'hFE03, 8'h46};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 8'h00};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00};

    repeat (3) next_cyc();
    nvec++;
    if ({busy, done, wen, r_addr, w_addr, w_data} !== 43'h0) begin
      nerr++;
      $display("FAIL reset_main: got busy=%b done=%b wen=%b ra=%h wa=%h wd=%h, want all 0",
               busy, done, wen, r_addr, w_addr, w_data);
    end
    nvec++;
    if ({busy5, done5, wen5, r_addr5, w_addr5, w_data5} !== 43'h0) begin
      nerr++;
      $display("FAIL reset_short: got busy=%b done=%b wen=%b ra=%h wa=%h wd=%h, want all 0",
               busy5, done5, wen5, r_addr5, w_addr5, w_data5);
    end
    rst_n = 1'b1;
    next_cyc();

    // Short instance: back-to-back, start-on-done, restart-on-write, echo map.
    for (int i = 0; i < 20; i++) begin
      start5 = tbl[i].st;
      page5  = tbl[i].pg;
      @(negedge clk);
      nvec++;
      if ({busy5, done5, wen5, r_addr5, w_addr5, w_data5} !==
          {tbl[i].busy, tbl[i].done, tbl[i].wen, tbl[i].ra, tbl[i].wa, tbl[i].wd}) begin
        nerr++;
        $display("FAIL short_row_%0d: got busy=%b done=%b wen=%b ra=%h wa=%h wd=%h, want busy=%b done=%b wen=%b ra=%h wa=%h wd=%h",
                 i, busy5, done5, wen5, r_addr5, w_addr5, w_data5,
                 tbl[i].busy, tbl[i].done, tbl[i].wen, tbl[i].ra, tbl[i].wa, tbl[i].wd);
      end
      @(posedge clk);
      #1;
    end
    start5 = 1'b0;

    // Plain transfer from C0.
    fill_dst();
    trig(8'hC0);
    start = 1'b0;
    wait_idle(800);
    check_dst("plain", 8'hC0, 160);

    // Echo page E1 reads from C1.
    fill_dst();
    trig(8'hE1);
    start = 1'b0;
    wait_idle(800);
    check_dst("echo", 8'hC1, 160);

    // Restart with D0 in cycle 100, which is byte 23's write cycle.
    fill_dst();
    trig(8'hC0);
    start = 1'b0;
    repeat (99) next_cyc();
    trig(8'hD0);
    start = 1'b0;
    wait_idle(800);
    check_dst("restart", 8'hD0, 160);

    // Async reset in cycle 294: bytes 0..71 landed, nothing after.
    fill_dst();
    trig(8'hC0);
    start = 1'b0;
    repeat (293) next_cyc();
    rst_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    b_until = b_from;
    #1;
    nvec++;
    if ({busy, done, wen, r_addr, w_addr, w_data} !== 43'h0) begin
      nerr++;
      $display("FAIL midreset: got busy=%b wen=%b ra=%h wa=%h, want all 0", busy, wen, r_addr, w_addr);
    end
    repeat (2) next_cyc();
    rst_n = 1'b1;
    repeat (20) next_cyc();
    check_dst("midreset", 8'hC0, 72);
    fill_dst();
    trig(8'hC0);
    start = 1'b0;
    wait_idle(800);
    check_dst("after_reset", 8'hC0, 160);

    // start held for three cycles acts as a trigger in the last one.
    fill_dst();
    trig(8'hC0);
    trig(8'hC1);
    trig(8'hC2);
    start = 1'b0;
    wait_idle(800);
    check_dst("held", 8'hC2, 160);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
